// File: rtl/bus_arbiter.sv
// Two-master round-robin arbiter in front of a single memory port.
// One transaction is in flight at a time; a stuck memory is aborted after TIMEOUT_CYCLES.
module bus_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter int unsigned CNT_W          = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] m0_address,
  input  logic [7:0]  m0_data_out,
  input  logic        m0_read,
  input  logic        m0_write,
  output logic [7:0]  m0_data_in,
  output logic        m0_done,
  output logic        m0_err,
  input  logic [15:0] m1_address,
  input  logic [7:0]  m1_data_out,
  input  logic        m1_read,
  input  logic        m1_write,
  output logic [7:0]  m1_data_in,
  output logic        m1_done,
  output logic        m1_err,
  output logic [15:0] mem_address,
  output logic [7:0]  mem_data_out,
  output logic        mem_read,
  output logic        mem_write,
  input  logic [7:0]  mem_data_in,
  input  logic        mem_done
);

  typedef enum logic [1:0] {StIdle, StGrant, StRelease} state_e;

  state_e            state_q, state_d;
  logic              last_grant_q, last_grant_d;
  logic              grant_q, grant_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [15:0]       mem_address_q, mem_address_d;
  logic [7:0]        mem_data_out_q, mem_data_out_d;
  logic              mem_read_q, mem_read_d;
  logic              mem_write_q, mem_write_d;

  logic req0, req1, winner, win_write, timeout, complete;

  always_comb begin
    req0      = m0_read | m0_write;
    req1      = m1_read | m1_write;
    // On a tie the master that did not win last time goes next.
    winner    = (req0 && req1) ? ~last_grant_q : req1;
    win_write = winner ? m1_write : m0_write;
    timeout   = (TIMEOUT_CYCLES != 0) && (state_q == StGrant) &&
                (cnt_q == CNT_W'(TIMEOUT_CYCLES)) && !mem_done;
    complete  = (state_q == StGrant) && (mem_done || timeout);
  end

  always_comb begin
    state_d        = state_q;
    last_grant_d   = last_grant_q;
    grant_d        = grant_q;
    cnt_d          = cnt_q;
    mem_address_d  = mem_address_q;
    mem_data_out_d = mem_data_out_q;
    mem_read_d     = mem_read_q;
    mem_write_d    = mem_write_q;
    unique case (state_q)
      StIdle: begin
        if (req0 || req1) begin
          grant_d        = winner;
          last_grant_d   = winner;
          mem_address_d  = winner ? m1_address : m0_address;
          mem_data_out_d = winner ? m1_data_out : m0_data_out;
          mem_write_d    = win_write;
          mem_read_d     = ~win_write;
          cnt_d          = '0;
          state_d        = StGrant;
        end
      end
      StGrant: begin
        if (complete) begin
          mem_read_d  = 1'b0;
          mem_write_d = 1'b0;
          cnt_d       = '0;
          state_d     = StRelease;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StRelease: begin
        mem_read_d  = 1'b0;
        mem_write_d = 1'b0;
        state_d     = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= StIdle;
      last_grant_q   <= 1'b1;
      grant_q        <= 1'b0;
      cnt_q          <= '0;
      mem_address_q  <= '0;
      mem_data_out_q <= '0;
      mem_read_q     <= 1'b0;
      mem_write_q    <= 1'b0;
    end else begin
      state_q        <= state_d;
      last_grant_q   <= last_grant_d;
      grant_q        <= grant_d;
      cnt_q          <= cnt_d;
      mem_address_q  <= mem_address_d;
      mem_data_out_q <= mem_data_out_d;
      mem_read_q     <= mem_read_d;
      mem_write_q    <= mem_write_d;
    end
  end

  always_comb begin
    mem_address  = mem_address_q;
    mem_data_out = mem_data_out_q;
    mem_read     = mem_read_q;
    mem_write    = mem_write_q;
    m0_data_in   = mem_data_in;
    m1_data_in   = mem_data_in;
    m0_done      = complete && !grant_q;
    m1_done      = complete && grant_q;
    m0_err       = timeout && !grant_q;
    m1_err       = timeout && grant_q;
  end

endmodule
